// File: rtl/mii_prbs_burst_checker_pkg.sv
// Shared PRBS9 taps, lock FSM encoding and the nibble-advance helper used by
// the MII PRBS burst checker.
package mii_prbs_burst_checker_pkg;

  localparam int PrbsTapHi_C = 9;
  localparam int PrbsTapLo_C = 5;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StLoad   = 2'd1,
    StSync   = 2'd2,
    StLocked = 2'd3
  } lockState_t;

  typedef struct packed {
    logic [8:0] nextState;
    logic [3:0] predNibble;
  } prbsStep_t;

  // Four serial PRBS9 steps; the first generated bit lands in nibble bit 3.
  function automatic prbsStep_t prbsAdvance(input logic [8:0] curState);
    prbsStep_t res;
    logic      bitNew;
    res.nextState  = curState;
    res.predNibble = '0;
    for (int k = 0; k < 4; k++) begin
      bitNew         = res.nextState[PrbsTapHi_C-1] ^ res.nextState[PrbsTapLo_C-1];
      res.nextState  = {res.nextState[7:0], bitNew};
      res.predNibble = {res.predNibble[2:0], bitNew};
    end
    return res;
  endfunction

endpackage

// File: rtl/prbs9_nibble_lfsr.sv
// Combinational one-nibble advance of the PRBS9 generator, shared by the
// SYNC compare path and the LOCKED free-running path.
module prbs9_nibble_lfsr
  import mii_prbs_burst_checker_pkg::*;
(
  input  logic [8:0] curState,
  output logic [8:0] nextState,
  output logic [3:0] predNibble
);

  prbsStep_t step;

  always_comb step = prbsAdvance(curState);

  assign nextState  = step.nextState;
  assign predNibble = step.predNibble;

endmodule

// File: rtl/mii_prbs_burst_checker.sv
// Self-synchronising PRBS9 checker with burst-length tracking on the MII RX side.
// Burst tracking is only built when BURST_LEN_CHK_EN is defined.
module mii_prbs_burst_checker
  import mii_prbs_burst_checker_pkg::*;
#(
  parameter int BurstLen_C    = 101,
  parameter int SyncNibbles_C = 8,
  parameter int LossNibbles_C = 4
) (
  input  logic        SysClk,
  input  logic        Reset,
  input  logic        MiiRxCEn,
  input  logic        MiiRxDV,
  input  logic [3:0]  MiiRxData,
  input  logic        CntClr,
  output logic        Locked,
  output logic        ErrPulse,
  output logic [31:0] BitErrCnt,
  output logic [15:0] BurstCnt,
  output logic [15:0] LenErrCnt,
  output logic [15:0] LastBurstLen
);

  localparam logic [7:0] SyncLim_C = 8'(SyncNibbles_C);
  localparam logic [7:0] LossLim_C = 8'(LossNibbles_C);

  lockState_t state, stateNext;
  logic [8:0] prbsState, prbsNext, lfsrNext;
  logic [3:0] predNibble;
  logic [7:0] goodCnt, goodNext, badCnt, badNext;
  logic [1:0] loadCnt, loadNext;
  logic       sampleValid, errHit;
  logic [2:0] errBits;
  logic [32:0] bitErrSum;

  assign sampleValid = MiiRxCEn & MiiRxDV;
  assign Locked      = (state == StLocked);

  prbs9_nibble_lfsr uLfsr (
    .curState  (prbsState),
    .nextState (lfsrNext),
    .predNibble(predNibble)
  );

  always_comb begin
    stateNext = state;
    prbsNext  = prbsState;
    goodNext  = goodCnt;
    badNext   = badCnt;
    loadNext  = loadCnt;
    errHit    = 1'b0;
    errBits   = 3'($countones(predNibble ^ MiiRxData));
    if (sampleValid) begin
      unique case (state)
        StHunt: begin
          prbsNext  = {prbsState[4:0], MiiRxData};
          loadNext  = 2'd1;
          stateNext = StLoad;
        end
        StLoad: begin
          prbsNext = {prbsState[4:0], MiiRxData};
          loadNext = loadCnt + 2'd1;
          if (loadCnt == 2'd2) begin
            stateNext = StSync;
            goodNext  = '0;
          end
        end
        StSync: begin
          // Reload from the wire so a bad seed is flushed within a few nibbles.
          prbsNext = {prbsState[4:0], MiiRxData};
          if (predNibble == MiiRxData) begin
            goodNext = goodCnt + 8'd1;
            if (goodCnt + 8'd1 == SyncLim_C) begin
              stateNext = StLocked;
              badNext   = '0;
            end
          end else begin
            goodNext = '0;
          end
        end
        StLocked: begin
          prbsNext = lfsrNext;
          if (predNibble != MiiRxData) begin
            errHit  = 1'b1;
            badNext = badCnt + 8'd1;
            if (badCnt + 8'd1 == LossLim_C) begin
              stateNext = StHunt;
              badNext   = '0;
              goodNext  = '0;
            end
          end else begin
            badNext = '0;
          end
        end
        default: stateNext = StHunt;
      endcase
    end
  end

  assign bitErrSum = {1'b0, BitErrCnt} + 33'(errBits);

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state     <= StHunt;
      prbsState <= '0;
      goodCnt   <= '0;
      badCnt    <= '0;
      loadCnt   <= '0;
      ErrPulse  <= 1'b0;
      BitErrCnt <= '0;
    end else begin
      state     <= stateNext;
      prbsState <= prbsNext;
      goodCnt   <= goodNext;
      badCnt    <= badNext;
      loadCnt   <= loadNext;
      ErrPulse  <= errHit;
      if (CntClr) begin
        BitErrCnt <= '0;
      end else if (errHit) begin
        BitErrCnt <= bitErrSum[32] ? 32'hFFFF_FFFF : bitErrSum[31:0];
      end
    end
  end

`ifdef BURST_LEN_CHK_EN
  localparam logic [15:0] BurstLim_C = 16'(BurstLen_C);

  logic [15:0] lenCnt;
  logic        burstEnd;

  assign burstEnd = MiiRxCEn & ~MiiRxDV & (lenCnt != 16'd0);

  // LenCnt is cleared by burst end only; CntClr leaves an in-flight burst intact.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      lenCnt       <= '0;
      BurstCnt     <= '0;
      LenErrCnt    <= '0;
      LastBurstLen <= '0;
    end else begin
      if (sampleValid) begin
        if (lenCnt != 16'hFFFF) lenCnt <= lenCnt + 16'd1;
      end else if (burstEnd) begin
        lenCnt <= '0;
      end
      if (CntClr) begin
        BurstCnt     <= '0;
        LenErrCnt    <= '0;
        LastBurstLen <= '0;
      end else if (burstEnd) begin
        BurstCnt     <= BurstCnt + 16'd1;
        LastBurstLen <= lenCnt;
        if (lenCnt != BurstLim_C && LenErrCnt != 16'hFFFF) LenErrCnt <= LenErrCnt + 16'd1;
      end
    end
  end
`else
  assign BurstCnt     = '0;
  assign LenErrCnt    = '0;
  assign LastBurstLen = '0;
`endif

endmodule

// File: tb/tb_mii_prbs_burst_checker.sv
// Bench for mii_prbs_burst_checker: burst-level vector table, reset/clear
// sequences and a randomized phase, all checked against a bit-history model.
module tb_mii_prbs_burst_checker;

  localparam int BurstLen    = 101;
  localparam int SyncNibbles = 8;
  localparam int LossNibbles = 4;
`ifdef BURST_LEN_CHK_EN
  localparam bit BurstOn = 1'b1;
`else
  localparam bit BurstOn = 1'b0;
`endif

  logic        SysClk, Reset, MiiRxCEn, MiiRxDV, CntClr;
  logic [3:0]  MiiRxData;
  logic        Locked, ErrPulse;
  logic [31:0] BitErrCnt;
  logic [15:0] BurstCnt, LenErrCnt, LastBurstLen;

  mii_prbs_burst_checker #(
    .BurstLen_C   (BurstLen),
    .SyncNibbles_C(SyncNibbles),
    .LossNibbles_C(LossNibbles)
  ) dut (
    .SysClk      (SysClk),
    .Reset       (Reset),
    .MiiRxCEn    (MiiRxCEn),
    .MiiRxDV     (MiiRxDV),
    .MiiRxData   (MiiRxData),
    .CntClr      (CntClr),
    .Locked      (Locked),
    .ErrPulse    (ErrPulse),
    .BitErrCnt   (BitErrCnt),
    .BurstCnt    (BurstCnt),
    .LenErrCnt   (LenErrCnt),
    .LastBurstLen(LastBurstLen)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  int errors = 0;
  int checks = 0;

  // Transmitter PRBS9 generator
  logic [8:0] txState;

  function automatic logic [3:0] txNext();
    logic [3:0] nib;
    logic       b;
    nib = '0;
    for (int k = 0; k < 4; k++) begin
      b       = txState[8] ^ txState[4];
      txState = {txState[7:0], b};
      nib     = {nib[2:0], b};
    end
    return nib;
  endfunction

  // Reference model: receiver state kept as a history of the bits it has absorbed
  bit      hist[$];
  int      mPhase, mGood, mBad;
  bit      mLocked, mPulse;
  longint  mBitErr;
  int      mLen, mBurst, mLenErr, mLast;

  function automatic logic [3:0] predictNib();
    bit         tmp[$];
    logic [3:0] p;
    bit         b;
    tmp = hist;
    p   = '0;
    for (int k = 0; k < 4; k++) begin
      b = tmp[tmp.size()-9] ^ tmp[tmp.size()-5];
      tmp.push_back(b);
      p[3-k] = b;
    end
    return p;
  endfunction

  task automatic pushNib(input logic [3:0] nib);
    for (int k = 3; k >= 0; k--) hist.push_back(nib[k]);
    while (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < 9; k++) hist.push_back(1'b0);
    mPhase = 0; mGood = 0; mBad = 0; mLocked = 0; mPulse = 0; mBitErr = 0;
    mLen = 0; mBurst = 0; mLenErr = 0; mLast = 0;
  endtask

  task automatic modelStep(input logic cen, input logic dv, input logic [3:0] d, input logic clr);
    logic [3:0] p;
    bit         hit;
    int         nbits;
    hit = 0; nbits = 0;
    if (cen && dv) begin
      p = predictNib();
      if (mLocked) begin
        pushNib(p);
        if (p != d) begin
          hit = 1; nbits = $countones(p ^ d); mBad++;
          if (mBad == LossNibbles) begin mLocked = 0; mPhase = 0; mBad = 0; end
        end else mBad = 0;
      end else if (mPhase < 3) begin
        pushNib(d); mPhase++; mGood = 0;
      end else begin
        mGood = (p == d) ? mGood + 1 : 0;
        pushNib(d);
        if (mGood == SyncNibbles) begin mLocked = 1; mBad = 0; mGood = 0; end
      end
    end
    mPulse = hit;
    if (clr) mBitErr = 0;
    else if (hit) begin
      mBitErr += nbits;
      if (mBitErr > 64'hFFFF_FFFF) mBitErr = 64'hFFFF_FFFF;
    end
    if (cen && dv) begin
      if (mLen < 65535) mLen++;
    end else if (cen && mLen > 0) begin
      if (!clr) begin
        mBurst = (mBurst + 1) % 65536;
        mLast  = mLen;
        if (mLen != BurstLen && mLenErr < 65535) mLenErr++;
      end
      mLen = 0;
    end
    if (clr) begin mBurst = 0; mLenErr = 0; mLast = 0; end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("Locked",       32'(Locked),       32'(mLocked));
    checkVal("ErrPulse",     32'(ErrPulse),     32'(mPulse));
    checkVal("BitErrCnt",    BitErrCnt,         mBitErr[31:0]);
    checkVal("BurstCnt",     32'(BurstCnt),     BurstOn ? 32'(mBurst)  : 32'd0);
    checkVal("LenErrCnt",    32'(LenErrCnt),    BurstOn ? 32'(mLenErr) : 32'd0);
    checkVal("LastBurstLen", 32'(LastBurstLen), BurstOn ? 32'(mLast)   : 32'd0);
  endtask

  task automatic applyStimulus(input logic cen, input logic dv, input logic [3:0] d, input logic clr);
    MiiRxCEn = cen; MiiRxDV = dv; MiiRxData = d; CntClr = clr;
    modelStep(cen, dv, d, clr);
    @(posedge SysClk);
    #1;
    checkOutput();
  endtask

  typedef struct {
    int          len;
    int          errFirst;
    int          errRun;
    logic [3:0]  errMask;
    int          gap;
    bit          clrAtEnd;
    int          lockAt;
    bit          expLocked;
    logic [31:0] expBitErr;
    logic [15:0] expBurst;
    logic [15:0] expLenErr;
    logic [15:0] expLast;
    int          expPulses;
  } burstVec_t;

  burstVec_t vecs[8];

  initial begin
    vecs[0] = '{101,  0, 0, 4'h0, 20, 1'b0, 11, 1'b1,  0, 1, 0, 101, 0};
    vecs[1] = '{101,  0, 0, 4'h0, 20, 1'b0,  0, 1'b1,  0, 2, 0, 101, 0};
    vecs[2] = '{101,  0, 0, 4'h0, 20, 1'b0,  0, 1'b1,  0, 3, 0, 101, 0};
    vecs[3] = '{101, 50, 1, 4'h4, 20, 1'b0,  0, 1'b1,  1, 4, 0, 101, 1};
    vecs[4] = '{101, 30, 4, 4'hF, 20, 1'b0, 44, 1'b1, 17, 5, 0, 101, 4};
    vecs[5] = '{100,  0, 0, 4'h0, 20, 1'b0,  0, 1'b1, 17, 6, 1, 100, 0};
    vecs[6] = '{101,  0, 0, 4'h0, 20, 1'b0,  0, 1'b1, 17, 7, 1, 101, 0};
    vecs[7] = '{ 99,  0, 0, 4'h0, 20, 1'b1,  0, 1'b1,  0, 0, 0,   0, 0};

    Reset = 1'b1; MiiRxCEn = 1'b0; MiiRxDV = 1'b0; MiiRxData = '0; CntClr = 1'b0;
    modelReset();
    repeat (2) @(posedge SysClk);
    #1;
    checkOutput();
    Reset   = 1'b0;
    txState = 9'h1FF;

    for (int v = 0; v < 8; v++) begin
      int pulses;
      pulses = 0;
      for (int n = 1; n <= vecs[v].len; n++) begin
        logic [3:0] nib;
        nib = txNext();
        if (vecs[v].errRun > 0 && n >= vecs[v].errFirst && n < vecs[v].errFirst + vecs[v].errRun)
          nib ^= vecs[v].errMask;
        applyStimulus(1'b1, 1'b1, nib, 1'b0);
        if (ErrPulse) pulses++;
        if (vecs[v].lockAt > 0 && n == vecs[v].lockAt - 1) checkVal("vecLockBefore", 32'(Locked), 32'd0);
        if (vecs[v].lockAt > 0 && n == vecs[v].lockAt)     checkVal("vecLockAt",     32'(Locked), 32'd1);
      end
      applyStimulus(1'b1, 1'b0, 4'h0, vecs[v].clrAtEnd);
      if (ErrPulse) pulses++;
      checkVal("vecLocked",    32'(Locked),       32'(vecs[v].expLocked));
      checkVal("vecBitErr",    BitErrCnt,         vecs[v].expBitErr);
      checkVal("vecBurst",     32'(BurstCnt),     BurstOn ? 32'(vecs[v].expBurst)  : 32'd0);
      checkVal("vecLenErr",    32'(LenErrCnt),    BurstOn ? 32'(vecs[v].expLenErr) : 32'd0);
      checkVal("vecLast",      32'(LastBurstLen), BurstOn ? 32'(vecs[v].expLast)   : 32'd0);
      checkVal("vecPulses",    32'(pulses),       32'(vecs[v].expPulses));
      for (int g = 1; g < vecs[v].gap; g++) applyStimulus(1'b1, 1'b0, 4'($urandom), 1'b0);
    end

    // Reset in the middle of a burst drops the partial burst.
    for (int n = 1; n <= 40; n++) applyStimulus(1'b1, 1'b1, txNext(), 1'b0);
    Reset = 1'b1;
    modelReset();
    #2;
    checkOutput();
    checkVal("rstBitErr", BitErrCnt, 32'd0);
    @(posedge SysClk);
    #1;
    Reset = 1'b0;
    for (int g = 0; g < 5; g++) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int n = 1; n <= 101; n++) applyStimulus(1'b1, 1'b1, txNext(), 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkVal("postRstLocked", 32'(Locked),       32'd1);
    checkVal("postRstBurst",  32'(BurstCnt),     BurstOn ? 32'd1   : 32'd0);
    checkVal("postRstLast",   32'(LastBurstLen), BurstOn ? 32'd101 : 32'd0);
    for (int g = 0; g < 5; g++) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);

    // Randomized traffic: enable gaps, error bursts, odd lengths and clears.
    for (int b = 0; b < 25; b++) begin
      int blen, gap, sent, errPct;
      logic       cen, clr;
      logic [3:0] nib;
      blen   = $urandom_range(98, 104);
      gap    = $urandom_range(2, 10);
      errPct = (b % 5 == 2) ? 60 : 2;
      sent   = 0;
      while (sent < blen) begin
        cen = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 199) == 0);
        nib = 4'($urandom);
        if (cen) begin
          nib = txNext();
          if ($urandom_range(0, 99) < errPct) nib ^= 4'($urandom_range(1, 15));
          sent++;
        end
        applyStimulus(cen, 1'b1, nib, clr);
      end
      for (int g = 0; g < gap; g++)
        applyStimulus($urandom_range(0, 3) != 0, 1'b0, 4'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
